// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared address offsets, load-mux select codes and TX state encoding
package uart_mmio_pkg;

  localparam logic [31:0] TX_OFFSET     = 32'd0;
  localparam logic [31:0] RX_OFFSET     = 32'd4;
  localparam logic [31:0] STATUS_OFFSET = 32'd8;

  localparam logic [1:0] SEL_MEM    = 2'b00;
  localparam logic [1:0] SEL_TX     = 2'b01;
  localparam logic [1:0] SEL_RX     = 2'b10;
  localparam logic [1:0] SEL_STATUS = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - TX handshake FSM: latch byte, one-cycle start pulse, wait for done
module uart_tx_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_wr,
  input  logic [7:0] wr_byte,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       tx_busy
);
  import uart_mmio_pkg::*;

  tx_state_t  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_data_d = wr_byte;
          state_d   = TX_START;
        end
      end
      TX_START:     state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (tx_done) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start = (state_q == TX_START);
  assign tx_busy  = (state_q != TX_IDLE);
  assign tx_data  = tx_data_q;

endmodule

// File: rtl/uart_mmio_controller.sv
// rtl/uart_mmio_controller.sv - memory-mapped UART glue: address decode, RX holding, TX sequencer
// Optional sticky RX overrun flag is built only when UART_RX_OVERRUN_EN is defined.
module uart_mmio_controller #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Mem_Write,
  input  logic                  Mem_Read,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  output logic [1:0]            Dev_Select,
  output logic [DATA_WIDTH-1:0] Dev_Read_Data,
  output logic                  Tx_Start,
  output logic [7:0]            Tx_Data,
  input  logic                  Tx_Done,
  input  logic [7:0]            Rx_Data,
  input  logic                  Rx_Valid
);
  import uart_mmio_pkg::*;

  logic       tx_busy;
  logic       tx_wr;
  logic       rx_rd;
  logic       rx_overrun;
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rx_full_q, rx_full_d;
  logic       unused_wdata;

  assign unused_wdata = ^Write_Data[DATA_WIDTH-1:8];

  always_comb begin
    Dev_Select = SEL_MEM;
    if (Address == BASE_ADDR + TX_OFFSET)          Dev_Select = SEL_TX;
    else if (Address == BASE_ADDR + RX_OFFSET)     Dev_Select = SEL_RX;
    else if (Address == BASE_ADDR + STATUS_OFFSET) Dev_Select = SEL_STATUS;
  end

  assign tx_wr = Mem_Write && (Dev_Select == SEL_TX);
  assign rx_rd = Mem_Read && (Dev_Select == SEL_RX);

  always_comb begin
    Dev_Read_Data = '0;
    case (Dev_Select)
      SEL_TX:     Dev_Read_Data[7:0] = Tx_Data;
      SEL_RX:     Dev_Read_Data[7:0] = rx_hold_q;
      SEL_STATUS: Dev_Read_Data[2:0] = {rx_overrun, rx_full_q, tx_busy};
      default:    Dev_Read_Data = '0;
    endcase
  end

  // A byte arriving on the same edge as the RX read wins: the fresh byte must not look consumed.
  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    if (Rx_Valid) begin
      rx_hold_d = Rx_Data;
      rx_full_d = 1'b1;
    end else if (rx_rd) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic rx_overrun_q, rx_overrun_d;
  logic status_wr;

  assign status_wr = Mem_Write && (Dev_Select == SEL_STATUS);

  // A new overrun on the clearing edge is kept so that no lost byte goes unreported.
  always_comb begin
    rx_overrun_d = rx_overrun_q;
    if (status_wr) rx_overrun_d = 1'b0;
    if (Rx_Valid && rx_full_q && !rx_rd) rx_overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rx_overrun_q <= 1'b0;
    else       rx_overrun_q <= rx_overrun_d;
  end

  assign rx_overrun = rx_overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

  uart_tx_sequencer u_tx_seq (
    .clk      (clk),
    .reset    (reset),
    .tx_wr    (tx_wr),
    .wr_byte  (Write_Data[7:0]),
    .tx_done  (Tx_Done),
    .tx_start (Tx_Start),
    .tx_data  (Tx_Data),
    .tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_mmio_controller.sv
// tb/tb_uart_mmio_controller.sv - directed and randomized bench for uart_mmio_controller with a behavioural model
module tb_uart_mmio_controller;

  localparam logic [31:0] A_TX = 32'h1001_0024;
  localparam logic [31:0] A_RX = 32'h1001_0028;
  localparam logic [31:0] A_ST = 32'h1001_002C;

  logic        clk = 1'b0;
  logic        reset;
  logic        Mem_Write, Mem_Read;
  logic [31:0] Address, Write_Data;
  logic [1:0]  Dev_Select;
  logic [31:0] Dev_Read_Data;
  logic        Tx_Start;
  logic [7:0]  Tx_Data;
  logic        Tx_Done;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid;

  always #5 clk = ~clk;

  uart_mmio_controller #(.DATA_WIDTH(32), .BASE_ADDR(32'h1001_0024)) dut (
    .clk           (clk),
    .reset         (reset),
    .Mem_Write     (Mem_Write),
    .Mem_Read      (Mem_Read),
    .Address       (Address),
    .Write_Data    (Write_Data),
    .Dev_Select    (Dev_Select),
    .Dev_Read_Data (Dev_Read_Data),
    .Tx_Start      (Tx_Start),
    .Tx_Data       (Tx_Data),
    .Tx_Done       (Tx_Done),
    .Rx_Data       (Rx_Data),
    .Rx_Valid      (Rx_Valid)
  );

  int checks = 0;
  int passed = 0;
  int start_seen = 0;

  bit       m_valid = 0;
  bit       m_busy, m_start, m_full, m_ovr;
  logic [7:0] m_tx, m_hold;

  function automatic logic [1:0] exp_sel(input logic [31:0] a);
    if (a == A_TX) return 2'b01;
    if (a == A_RX) return 2'b10;
    if (a == A_ST) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a == A_TX) return {24'b0, m_tx};
    if (a == A_RX) return {24'b0, m_hold};
    if (a == A_ST) return {29'b0, m_ovr, m_full, m_busy};
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] wd, input bit txd, input bit rxv, input logic [7:0] rxd);
    bit acc, rdrx;
    reset = rst; Mem_Write = wr; Mem_Read = rd; Address = a; Write_Data = wd;
    Tx_Done = txd; Rx_Valid = rxv; Rx_Data = rxd;
    #2;
    if (Tx_Start === 1'b1) start_seen++;
    if (m_valid) begin
      chk("dev_select", {30'b0, Dev_Select}, {30'b0, exp_sel(a)});
      chk("dev_read_data", Dev_Read_Data, exp_rdata(a));
      chk("tx_start", {31'b0, Tx_Start}, {31'b0, m_start});
      chk("tx_data", {24'b0, Tx_Data}, {24'b0, m_tx});
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1; m_busy = 0; m_start = 0; m_tx = 8'h00;
      m_hold = 8'h00; m_full = 0; m_ovr = 0;
    end else begin
      acc  = !m_busy && wr && (a == A_TX);
      rdrx = rd && (a == A_RX);
      if (acc) begin
        m_tx   = wd[7:0];
        m_busy = 1;
      end else if (m_busy && !m_start && txd) begin
        m_busy = 0;
      end
      m_start = acc;
`ifdef UART_RX_OVERRUN_EN
      if (wr && (a == A_ST)) m_ovr = 0;
      if (rxv && m_full && !rdrx) m_ovr = 1;
`endif
      if (rxv) begin
        m_hold = rxd;
        m_full = 1;
      end else if (rdrx) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  logic [31:0] ra;
  logic [31:0] exp_ovr_status;

  initial begin
    reset = 1; Mem_Write = 0; Mem_Read = 0; Address = 0; Write_Data = 0;
    Tx_Done = 0; Rx_Valid = 0; Rx_Data = 0;
    @(posedge clk); #1;

    // reset, then one transmission with a write attempted while busy
    cyc(1, 1, 1, A_TX, 32'hFF, 1, 1, 8'hEE);
    chk("reset_status", Dev_Read_Data, 32'h0);
    chk("reset_tx_start", {31'b0, Tx_Start}, 32'h0);
    start_seen = 0;
    cyc(0, 1, 0, A_TX, 32'hDEAD_BE41, 0, 0, 8'h00);
    cyc(0, 1, 0, A_TX, 32'h42, 0, 0, 8'h00);
    cyc(0, 1, 0, A_TX, 32'h42, 0, 0, 8'h00);
    cyc(0, 0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("busy_status", Dev_Read_Data, 32'h1);
    chk("busy_tx_data", {24'b0, Tx_Data}, 32'h41);
    cyc(0, 0, 1, A_ST, 32'h0, 1, 0, 8'h00);
    chk("done_status", Dev_Read_Data, 32'h0);
    chk("done_tx_data", {24'b0, Tx_Data}, 32'h41);
    chk("single_pulse", start_seen, 1);

    // RX hold and read-clear
    cyc(0, 0, 0, A_ST, 32'h0, 0, 1, 8'h5A);
    chk("rx_full_status", Dev_Read_Data, 32'h2);
    cyc(0, 0, 1, A_RX, 32'h0, 0, 0, 8'h00);
    chk("rx_read_value", Dev_Read_Data, 32'h5A);
    chk("rx_read_sel", {30'b0, Dev_Select}, 32'h2);
    cyc(0, 0, 1, A_ST, 32'h0, 0, 0, 8'h00);
    chk("rx_cleared_status", Dev_Read_Data, 32'h0);

    // new byte on the same edge as the read
    cyc(0, 0, 0, A_ST, 32'h0, 0, 1, 8'h11);
    cyc(0, 0, 1, A_RX, 32'h0, 0, 1, 8'h33);
    chk("rx_collide_hold", Dev_Read_Data, 32'h33);
    cyc(0, 0, 0, A_ST, 32'h0, 0, 0, 8'h00);
    chk("rx_collide_status", Dev_Read_Data, 32'h2);

    // overrun, cleared by a status store
`ifdef UART_RX_OVERRUN_EN
    exp_ovr_status = 32'h6;
`else
    exp_ovr_status = 32'h2;
`endif
    cyc(1, 0, 0, A_ST, 32'h0, 0, 0, 8'h00);
    cyc(0, 0, 0, A_ST, 32'h0, 0, 1, 8'hAA);
    cyc(0, 0, 0, A_ST, 32'h0, 0, 1, 8'hBB);
    chk("overrun_status", Dev_Read_Data, exp_ovr_status);
    cyc(0, 1, 0, A_ST, 32'hFFFF_FFFF, 0, 0, 8'h00);
    chk("overrun_cleared", Dev_Read_Data, 32'h2);

    // reset while waiting for done abandons the byte
    cyc(0, 1, 0, A_TX, 32'h77, 0, 0, 8'h00);
    cyc(0, 0, 0, A_ST, 32'h0, 0, 0, 8'h00);
    cyc(0, 0, 0, A_ST, 32'h0, 0, 0, 8'h00);
    cyc(1, 1, 0, A_TX, 32'h99, 0, 0, 8'h00);
    chk("rst_mid_tx_start", {31'b0, Tx_Start}, 32'h0);
    chk("rst_mid_tx_data", {24'b0, Tx_Data}, 32'h0);
    cyc(0, 0, 0, A_ST, 32'h0, 1, 0, 8'h00);
    chk("rst_mid_status", Dev_Read_Data, 32'h0);
    chk("rst_mid_no_pulse", {31'b0, Tx_Start}, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: ra = A_TX;
        1: ra = A_RX;
        2: ra = A_ST;
        3: ra = A_ST + 32'd4;
        4: ra = A_TX - 32'd4;
        default: ra = $urandom;
      endcase
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
          ra, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
